// File: rtl/booth_mult.sv
// booth_mult: iterative radix-2 Booth signed 32x32 multiplier.
// Drives an external 32-bit adder each RUN cycle and folds its sum back into
// the 65-bit product register {HI, LO, q_1} with an arithmetic right shift.
module booth_mult (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_q1;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;

    logic        w_sign;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic        w_exc_nxt;

    // Adder operand select from registered state only; zero outside RUN
    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_a = r_hi;
            case ({r_lo[0], r_q1})
                2'b01: begin
                    add_b   = r_m;
                end
                2'b10: begin
                    add_b   = ~r_m;
                    add_cin = 1'b1;
                end
                default: begin
                    add_b   = 32'd0;
                end
            endcase
        end
    end

    // The adder's sign bit is wrong on overflow; XOR restores the true
    // 33-bit sign so the arithmetic shift stays exact for -2^31 operands.
    assign w_sign    = add_sum[31] ^ add_overflow;
    assign w_hi_nxt  = {w_sign, add_sum[31:1]};
    assign w_lo_nxt  = {add_sum[0], r_lo[31:1]};
    assign w_exc_nxt = (w_hi_nxt != {32{w_lo_nxt[31]}});

    // Control FSM, product register update and registered result outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_m      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_q1     <= 1'b0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_q1  <= r_lo[0];
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= DONE;
                        r_result <= w_lo_nxt;
                        r_exc    <= w_exc_nxt;
                        r_rdy    <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new start
                    r_rdy <= 1'b0;
                    if (ctrl_MULT) begin
                        r_state <= RUN;
                        r_m     <= data_operandA;
                        r_hi    <= 32'd0;
                        r_lo    <= data_operandB;
                        r_q1    <= 1'b0;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed vectors for booth_mult with a behavioural adder,
// a product/timing model and a per-cycle output compare process.
module tb_booth_mult;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_overflow;

    booth_mult dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_cin        (add_cin),
        .add_sum        (add_sum),
        .add_overflow   (add_overflow)
    );

    // Behavioural stand-in for the shared carry-lookahead adder
    assign add_sum      = add_a + add_b + {31'd0, add_cin};
    assign add_overflow = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held_res = 32'd0;
    logic        held_exc = 1'b0;
    int          last_start = -1000;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference product: {exception, low word} from plain 64-bit arithmetic
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        logic ex;
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        ex = (p != longint'($signed(lo)));
        return {ex, lo};
    endfunction

    function automatic bit in_run(input int c);
        return (c >= last_start + 1) && (c <= last_start + 32);
    endfunction

    // Per-cycle compare against the model
    always @(negedge clock) begin
        if (!resetn) begin
            chk("rst_rdy", 64'(data_resultRDY), 64'd0);
            chk("rst_res", 64'(data_result), 64'd0);
            chk("rst_exc", 64'(data_exception), 64'd0);
            chk("rst_add", {31'd0, add_cin, add_a | add_b}, 64'd0);
        end else begin
            logic exp_rdy;
            exp_rdy = (q.size() > 0) && (q[0].due == cyc);
            chk("rdy", 64'(data_resultRDY), 64'(exp_rdy));
            if (exp_rdy) begin
                held_res = q[0].res;
                held_exc = q[0].exc;
                void'(q.pop_front());
            end
            chk("res", 64'(data_result), 64'(held_res));
            chk("exc", 64'(data_exception), 64'(held_exc));
            if (!in_run(cyc))
                chk("add_idle", {31'd0, add_cin, add_a | add_b}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    // Present a start for one cycle; the model accepts it unless RUN is active
    task automatic go(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        if (!in_run(cyc)) begin
            r = model(a, b);
            q.push_back('{cyc + 33, r[31:0], r[32]});
            last_start = cyc;
        end
        tick();
        ctrl_MULT = 1'b0;
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee, input string name);
        int s;
        chk({name, "_model"}, 64'(model(a, b)), {31'd0, ee, er});
        s = cyc;
        go(a, b);
        wait_to(s + 33);
        chk({name, "_rdy"}, 64'(data_resultRDY), 64'd1);
        chk({name, "_res"}, 64'(data_result), 64'(er));
        chk({name, "_exc"}, 64'(data_exception), 64'(ee));
        chk({name, "_add0"}, {31'd0, add_cin, add_a | add_b}, 64'd0);
        tick();
        chk({name, "_rdy_off"}, 64'(data_resultRDY), 64'd0);
    endtask

    initial begin
        int s;
        repeat (3) tick();
        chk("reset_res", 64'(data_result), 64'd0);
        chk("reset_rdy", 64'(data_resultRDY), 64'd0);
        resetn = 1'b1;
        tick();

        directed(32'd3, 32'd5, 32'h0000000F, 1'b0, "3x5");
        directed(-32'sd7, 32'd6, 32'hFFFFFFD6, 1'b0, "m7x6");
        directed(-32'sd7, -32'sd6, 32'h0000002A, 1'b0, "m7xm6");
        directed(32'h80000000, 32'h80000000, 32'h00000000, 1'b1, "min_sq");
        directed(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "min_x_m1");
        directed(32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "2p16_sq");
        directed(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, "max_x1");

        // Start during RUN is ignored
        s = cyc;
        go(32'd11, 32'd13);
        wait_to(s + 10);
        go(32'd100, 32'd100);
        wait_to(s + 33);
        chk("ignore_rdy", 64'(data_resultRDY), 64'd1);
        chk("ignore_res", 64'(data_result), 64'd143);
        wait_to(s + 70);

        // Reset during RUN discards the operation
        s = cyc;
        go(32'd9, 32'd9);
        wait_to(s + 12);
        resetn = 1'b0;
        q.delete();
        held_res = 32'd0;
        held_exc = 1'b0;
        last_start = -1000;
        #1;
        chk("midrst_res", 64'(data_result), 64'd0);
        chk("midrst_add", {31'd0, add_cin, add_a | add_b}, 64'd0);
        tick();
        tick();
        resetn = 1'b1;
        wait_to(s + 40);

        // Back-to-back: second start in the DONE cycle of the first
        s = cyc;
        go(32'd2, 32'd3);
        wait_to(s + 33);
        chk("b2b1_rdy", 64'(data_resultRDY), 64'd1);
        chk("b2b1_res", 64'(data_result), 64'd6);
        go(32'd4, 32'd5);
        wait_to(s + 66);
        chk("b2b2_rdy", 64'(data_resultRDY), 64'd1);
        chk("b2b2_res", 64'(data_result), 64'd20);
        repeat (5) tick();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d results never seen, expected 0", q.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
